// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
//   Generic inter-stage pipeline register with a valid/ready handshake and a
//   two-entry skid buffer. The main entry drives the outputs and the skid
//   entry absorbs one beat of overlap, so the upstream ready is taken from a
//   register rather than from the downstream ready.
//
//   Controls, in order of priority on each edge:
//   reset (asynchronous) > flush (bubble) > keep (stall) > normal flow.
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        asynchronous reset, active low
//   flush_i      drop both entries and drive BUBBLE_VAL on data_o
//   keep_i       freeze the stage: nothing is accepted and nothing is released
//   valid_i      upstream beat valid
//   data_i       upstream payload
//   ready_o      stage accepts a beat this cycle
//   valid_o      data_o holds a valid beat
//   data_o       head payload (main entry)
//   ready_i      downstream accepts the head
//   occ_o        number of entries held, 0..2
//   stall_cnt_o  saturating count of cycles in which the head was stalled
//   stall_clr_i  synchronous clear of stall_cnt_o
module pipe_stage_reg #(
  parameter int unsigned            WIDTH      = 32,
  parameter logic [WIDTH-1:0]       BUBBLE_VAL = '0,
  parameter int unsigned            CNT_W      = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             keep_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             ready_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  input  logic             ready_i,
  output logic [1:0]       occ_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  input  logic             stall_clr_i
);

  logic             main_valid;
  logic [WIDTH-1:0] main_data;
  logic             skid_valid;
  logic [WIDTH-1:0] skid_data;
  logic [CNT_W-1:0] stall_cnt;

  logic             in_fire;
  logic             out_fire;
  logic             head_stalled;

  // ready_o only looks at the registered skid state plus keep_i, so the
  // downstream ready never propagates combinationally to the upstream stage.
  assign ready_o      = ~skid_valid & ~keep_i;
  assign in_fire      = valid_i & ready_o;
  assign out_fire     = main_valid & ready_i & ~keep_i;
  assign head_stalled = main_valid & (~ready_i | keep_i);

  assign valid_o     = main_valid;
  assign data_o      = main_data;
  assign occ_o       = {1'b0, main_valid} + {1'b0, skid_valid};
  assign stall_cnt_o = stall_cnt;

  // Entry storage. data_o keeps its last payload when the main entry drains;
  // it only changes on a load, a flush or a reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      main_valid <= 1'b0;
      main_data  <= BUBBLE_VAL;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (flush_i) begin
      // A beat offered in the same cycle is dropped along with the entries.
      main_valid <= 1'b0;
      main_data  <= BUBBLE_VAL;
      skid_valid <= 1'b0;
    end else if (keep_i) begin
      main_valid <= main_valid;
      main_data  <= main_data;
      skid_valid <= skid_valid;
      skid_data  <= skid_data;
    end else if (out_fire) begin
      if (skid_valid) begin
        // Skid moves up to the head, keeping arrival order.
        main_data <= skid_data;
        if (in_fire) begin
          skid_data <= data_i;
        end else begin
          skid_valid <= 1'b0;
        end
      end else if (in_fire) begin
        main_data <= data_i;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (in_fire) begin
      if (!main_valid) begin
        main_valid <= 1'b1;
        main_data  <= data_i;
      end else begin
        // Head is stuck: the new beat lands in the (empty) skid entry and
        // ready_o falls on the following cycle.
        skid_valid <= 1'b1;
        skid_data  <= data_i;
      end
    end
  end

  // Stall counter: clear wins over increment, flush suppresses counting but
  // does not clear, and the count saturates instead of wrapping.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt <= '0;
    end else if (stall_clr_i) begin
      stall_cnt <= '0;
    end else if (head_stalled && !flush_i && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        flush_i, keep_i, valid_i, ready_i, stall_clr_i;
  logic [31:0] data_i;
  logic        ready_o, valid_o;
  logic [31:0] data_o;
  logic [1:0]  occ_o;
  logic [15:0] stall_cnt_o;

  logic        d2_ready, d2_valid;
  logic [31:0] d2_data;
  logic [1:0]  d2_occ;
  logic [1:0]  d2_cnt;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  always #5 clk_i = ~clk_i;

  pipe_stage_reg #(.WIDTH(32), .BUBBLE_VAL(32'h0), .CNT_W(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .keep_i(keep_i),
    .valid_i(valid_i), .data_i(data_i), .ready_o(ready_o),
    .valid_o(valid_o), .data_o(data_o), .ready_i(ready_i),
    .occ_o(occ_o), .stall_cnt_o(stall_cnt_o), .stall_clr_i(stall_clr_i)
  );

  // Second instance with a 2-bit counter, driven by the same inputs, used
  // only for the saturation checks.
  pipe_stage_reg #(.WIDTH(32), .BUBBLE_VAL(32'h0), .CNT_W(2)) dut2 (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .keep_i(keep_i),
    .valid_i(valid_i), .data_i(data_i), .ready_o(d2_ready),
    .valid_o(d2_valid), .data_o(d2_data), .ready_i(ready_i),
    .occ_o(d2_occ), .stall_cnt_o(d2_cnt), .stall_clr_i(stall_clr_i)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every beat leaving the stage is compared with the queue head.
  always @(negedge clk_i) begin
    if (rst_i === 1'b1 && valid_o === 1'b1 && ready_i && !keep_i && !flush_i) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_beat: got %h expected no beat", data_o);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (data_o !== e) begin
          errors++;
          $display("FAIL out_beat: got %h expected %h", data_o, e);
        end
      end
    end
  end

  // One clock cycle with the inputs as currently set: checks ready/occupancy
  // at the falling edge, records the beat the bench expects to be accepted,
  // then advances to just after the next rising edge.
  task automatic cyc(input logic exp_rdy, input logic [1:0] exp_occ);
    @(negedge clk_i);
    chk("ready_o", {31'b0, ready_o}, {31'b0, exp_rdy});
    chk("occ_o", {30'b0, occ_o}, {30'b0, exp_occ});
    if (flush_i) exp_q.delete();
    else if (valid_i && exp_rdy) exp_q.push_back(data_i);
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_i = 1'b0; flush_i = 0; keep_i = 0; valid_i = 0; ready_i = 0;
    stall_clr_i = 0; data_i = '0;
    repeat (2) @(negedge clk_i);
    chk("rst_valid", {31'b0, valid_o}, 32'd0);
    chk("rst_data", data_o, 32'h0);
    chk("rst_occ", {30'b0, occ_o}, 32'd0);
    chk("rst_cnt", {16'b0, stall_cnt_o}, 32'd0);
    chk("rst_ready", {31'b0, ready_o}, 32'd1);
    @(posedge clk_i); #1;
    rst_i = 1'b1;

    // Streaming at full rate.
    ready_i = 1;
    for (int i = 1; i <= 5; i++) begin
      valid_i = 1; data_i = 32'hA000_0000 + i;
      cyc(1'b1, (i == 1) ? 2'd0 : 2'd1);
      if (i == 1) chk("lat1_valid", {31'b0, valid_o}, 32'd1);
    end
    valid_i = 0;
    cyc(1'b1, 2'd1);
    cyc(1'b1, 2'd0);
    chk("drain_valid", {31'b0, valid_o}, 32'd0);
    chk("drain_data", data_o, 32'hA000_0005);

    // Backpressure into the skid entry.
    ready_i = 0;
    valid_i = 1; data_i = 32'hC000_0001; cyc(1'b1, 2'd0);
    data_i = 32'hC000_0002;              cyc(1'b1, 2'd1);
    data_i = 32'hC000_0003;              cyc(1'b0, 2'd2);
    cyc(1'b0, 2'd2);
    chk("bp_cnt", {16'b0, stall_cnt_o}, 32'd3);
    ready_i = 1;
    cyc(1'b0, 2'd2);
    cyc(1'b1, 2'd1);
    valid_i = 0;
    cyc(1'b1, 2'd1);
    cyc(1'b1, 2'd0);
    chk("bp_cnt_hold", {16'b0, stall_cnt_o}, 32'd3);

    // Flush with keep and a new beat in the same cycle.
    ready_i = 0;
    valid_i = 1; data_i = 32'hD000_0001; cyc(1'b1, 2'd0);
    data_i = 32'hD000_0002;              cyc(1'b1, 2'd1);
    flush_i = 1; keep_i = 1; data_i = 32'hD000_0003;
    cyc(1'b0, 2'd2);
    flush_i = 0; keep_i = 0; valid_i = 0;
    chk("flush_valid", {31'b0, valid_o}, 32'd0);
    chk("flush_data", data_o, 32'h0);
    chk("flush_cnt", {16'b0, stall_cnt_o}, 32'd4);
    cyc(1'b1, 2'd0);
    stall_clr_i = 1; cyc(1'b1, 2'd0); stall_clr_i = 0;
    chk("clr_cnt", {16'b0, stall_cnt_o}, 32'd0);

    // Keep for two cycles with the head ready to leave.
    ready_i = 1;
    valid_i = 1; data_i = 32'hE000_0001; cyc(1'b1, 2'd0);
    keep_i = 1;  data_i = 32'hE000_0002;
    cyc(1'b0, 2'd1);
    chk("keep_data1", data_o, 32'hE000_0001);
    chk("keep_cnt1", {16'b0, stall_cnt_o}, 32'd1);
    cyc(1'b0, 2'd1);
    chk("keep_data2", data_o, 32'hE000_0001);
    chk("keep_cnt2", {16'b0, stall_cnt_o}, 32'd2);
    keep_i = 0;
    cyc(1'b1, 2'd1);
    valid_i = 0;
    cyc(1'b1, 2'd1);
    cyc(1'b1, 2'd0);
    chk("keep_cnt_end", {16'b0, stall_cnt_o}, 32'd2);

    // Counter saturation on the 2-bit instance, then clear during a stall.
    stall_clr_i = 1; cyc(1'b1, 2'd0); stall_clr_i = 0;
    ready_i = 0;
    valid_i = 1; data_i = 32'hF000_0001; cyc(1'b1, 2'd0);
    valid_i = 0;
    for (int i = 1; i <= 6; i++) begin
      cyc(1'b1, 2'd1);
      chk("sat_cnt", {30'b0, d2_cnt}, (i < 3) ? i : 3);
      chk("wide_cnt", {16'b0, stall_cnt_o}, i);
    end
    stall_clr_i = 1; cyc(1'b1, 2'd1); stall_clr_i = 0;
    chk("clr_sat_cnt", {30'b0, d2_cnt}, 32'd0);
    chk("clr_wide_cnt", {16'b0, stall_cnt_o}, 32'd0);
    ready_i = 1;
    cyc(1'b1, 2'd1);
    cyc(1'b1, 2'd0);

    // Asynchronous reset with two entries held.
    ready_i = 0;
    valid_i = 1; data_i = 32'h6000_0001; cyc(1'b1, 2'd0);
    data_i = 32'h6000_0002;              cyc(1'b1, 2'd1);
    valid_i = 0;
    chk("pre_rst_occ", {30'b0, occ_o}, 32'd2);
    #2 rst_i = 0;
    #1;
    chk("arst_valid", {31'b0, valid_o}, 32'd0);
    chk("arst_occ", {30'b0, occ_o}, 32'd0);
    chk("arst_data", data_o, 32'h0);
    chk("arst_ready", {31'b0, ready_o}, 32'd1);
    chk("arst_cnt", {16'b0, stall_cnt_o}, 32'd0);
    exp_q.delete();
    @(posedge clk_i); #1;
    rst_i = 1;
    ready_i = 1;
    valid_i = 1; data_i = 32'hB000_0001; cyc(1'b1, 2'd0);
    valid_i = 0;
    cyc(1'b1, 2'd1);
    cyc(1'b1, 2'd0);

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
